// File: rtl/load_response_unit.sv
// Delayed-load consumer: issues one data-memory read per accepted load, stalls the
// pipeline until the response arrives, then aligns/extends it and writes it back.
module load_response_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        delayed_load,
  input  logic [4:0]  delayed_rd,
  input  logic [31:0] delayed_addr,
  input  logic [2:0]  delayed_funct3,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        load_stall_o,
  output logic        load_fault
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t        state_q, state_d;
  logic [4:0]    rd_q, rd_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          req_q, req_d, stall_q, stall_d, we_q, we_d, fault_q, fault_d;
  logic          illegal, timeout;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   aligned;

  assign illegal = (delayed_funct3 == 3'b011) || (delayed_funct3 == 3'b110) ||
                   (delayed_funct3 == 3'b111) ||
                   ((delayed_funct3[1:0] == 2'b01) && delayed_addr[0]) ||
                   ((delayed_funct3 == 3'b010) && (delayed_addr[1:0] != 2'b00));

  // Counter saturates at TIMEOUT so it can never wrap back below the limit.
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign timeout = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    rbyte   = dmem_rdata[{off_q, 3'b000} +: 8];
    rhalf   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    aligned = dmem_rdata;
    case (f3_q[1:0])
      2'b00:   aligned = {{24{rbyte[7] & ~f3_q[2]}}, rbyte};
      2'b01:   aligned = {{16{rhalf[15] & ~f3_q[2]}}, rhalf};
      default: aligned = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    off_d       = off_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    dmem_addr_d = dmem_addr_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (delayed_load) begin
          if (illegal) begin
            fault_d = 1'b1;
          end else begin
            rd_d        = delayed_rd;
            off_d       = delayed_addr[1:0];
            f3_d        = delayed_funct3;
            cnt_d       = '0;
            dmem_addr_d = {delayed_addr[31:2], 2'b00};
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (dmem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (dmem_rvalid) begin
          wb_data_d = aligned;
          wb_rd_d   = rd_q;
          state_d   = WB;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered copies of what the next state implies.
    req_d   = (state_d == REQ);
    stall_d = (state_d != IDLE);
    we_d    = (state_d == WB) && (rd_q != 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      cnt_q       <= '0;
      dmem_addr_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      req_q       <= 1'b0;
      stall_q     <= 1'b0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      dmem_addr_q <= dmem_addr_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      req_q       <= req_d;
      stall_q     <= stall_d;
      we_q        <= we_d;
      fault_q     <= fault_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_addr    = dmem_addr_q;
  assign wb_we        = we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign load_stall_o = stall_q;
  assign load_fault   = fault_q;
endmodule

// File: tb/tb_load_response_unit.sv
// Directed bench for load_response_unit; writebacks are checked against a scoreboard
// queue filled when each load is issued.
module tb_load_response_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        delayed_load;
  logic [4:0]  delayed_rd;
  logic [31:0] delayed_addr;
  logic [2:0]  delayed_funct3;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        load_stall_o;
  logic        load_fault;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  load_response_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .delayed_load(delayed_load), .delayed_rd(delayed_rd),
    .delayed_addr(delayed_addr), .delayed_funct3(delayed_funct3),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .load_stall_o(load_stall_o), .load_fault(load_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    wb_t e;
    @(posedge clk);
    #1;
    if (wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_we", wb_we, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_wb_rd", wb_rd, e.rd);
        chk("sb_wb_data", wb_data, e.data);
      end
    end
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    delayed_load   = 1'b1;
    delayed_funct3 = f3;
    delayed_rd     = rd;
    delayed_addr   = addr;
  endtask

  // Minimum-latency load: gnt in cycle 1, rvalid in cycle 2, writeback in cycle 3.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] expv);
    drive_load(f3, rd, addr);
    if (rd != 5'd0) sb.push_back('{rd: rd, data: expv});
    cyc();
    delayed_load = 1'b0;
    chk({tag, "_req"}, dmem_req, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    cyc();
    dmem_rvalid = 1'b0;
    chk({tag, "_we"}, wb_we, {31'd0, rd != 5'd0});
    cyc();
    chk({tag, "_stall_done"}, load_stall_o, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    delayed_load = 1'b0; delayed_rd = '0; delayed_addr = '0; delayed_funct3 = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    cyc(); cyc();
    chk("rst_req", dmem_req, 32'd0);
    chk("rst_stall", load_stall_o, 32'd0);
    chk("rst_we", wb_we, 32'd0);
    chk("rst_fault", load_fault, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    #2 rst = 1'b1;
    cyc();

    // 1: basic lw with exact cycle-by-cycle timing
    drive_load(3'b010, 5'd5, 32'h100);
    sb.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    cyc();
    delayed_load = 1'b0;
    chk("t1_c1_req", dmem_req, 32'd1);
    chk("t1_c1_stall", load_stall_o, 32'd1);
    chk("t1_c1_addr", dmem_addr, 32'h100);
    chk("t1_c1_we", wb_we, 32'd0);
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    chk("t1_c2_req", dmem_req, 32'd0);
    chk("t1_c2_stall", load_stall_o, 32'd1);
    chk("t1_c2_we", wb_we, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    cyc();
    dmem_rvalid = 1'b0;
    chk("t1_c3_we", wb_we, 32'd1);
    chk("t1_c3_stall", load_stall_o, 32'd1);
    cyc();
    chk("t1_c4_we", wb_we, 32'd0);
    chk("t1_c4_stall", load_stall_o, 32'd0);

    // 2: alignment and extension
    do_load("t2_lb",  3'b000, 5'd1, 32'h103, 32'h80018000, 32'hFFFFFF80);
    do_load("t2_lbu", 3'b100, 5'd2, 32'h103, 32'h80018000, 32'h00000080);
    do_load("t2_lh",  3'b001, 5'd3, 32'h102, 32'h80018000, 32'hFFFF8001);
    do_load("t2_lhu", 3'b101, 5'd4, 32'h100, 32'h80018000, 32'h00008000);
    do_load("t2_lbu1", 3'b100, 5'd6, 32'h101, 32'h80018000, 32'h00000080);

    // 3: misaligned lw and illegal funct3 fault without issuing
    drive_load(3'b010, 5'd7, 32'h102);
    cyc();
    delayed_load = 1'b0;
    chk("t3a_fault", load_fault, 32'd1);
    chk("t3a_req", dmem_req, 32'd0);
    chk("t3a_stall", load_stall_o, 32'd0);
    cyc();
    chk("t3a_fault_pulse", load_fault, 32'd0);
    chk("t3a_req2", dmem_req, 32'd0);
    drive_load(3'b011, 5'd7, 32'h100);
    cyc();
    delayed_load = 1'b0;
    chk("t3b_fault", load_fault, 32'd1);
    chk("t3b_stall", load_stall_o, 32'd0);
    cyc();
    chk("t3b_fault_pulse", load_fault, 32'd0);
    chk("t3b_we", wb_we, 32'd0);

    // 4: gnt withheld 4 cycles, rd=0; rvalid coinciding with gnt is ignored
    drive_load(3'b010, 5'd0, 32'h204);
    cyc();
    delayed_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_req_hold", dmem_req, 32'd1);
      chk("t4_addr_hold", dmem_addr, 32'h204);
      cyc();
    end
    chk("t4_req_c5", dmem_req, 32'd1);
    chk("t4_stall_c5", load_stall_o, 32'd1);
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    cyc();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk("t4_req_drop", dmem_req, 32'd0);
    cyc();
    chk("t4_still_wait", load_stall_o, 32'd1);
    dmem_rvalid = 1'b1;
    cyc();
    dmem_rvalid = 1'b0;
    chk("t4_wb_stall", load_stall_o, 32'd1);
    chk("t4_no_we", wb_we, 32'd0);
    cyc();
    chk("t4_idle", load_stall_o, 32'd0);

    // 5: timeout 16 cycles after REQ entry
    drive_load(3'b010, 5'd8, 32'h300);
    cyc();
    delayed_load = 1'b0;
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      chk("t5_stall_hold", load_stall_o, 32'd1);
      chk("t5_no_fault", load_fault, 32'd0);
      if (c < 16) cyc();
    end
    cyc();
    chk("t5_fault", load_fault, 32'd1);
    chk("t5_stall_drop", load_stall_o, 32'd0);
    chk("t5_req_drop", dmem_req, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    cyc();
    dmem_rvalid = 1'b0;
    chk("t5_fault_pulse", load_fault, 32'd0);
    cyc();
    chk("t5_late_no_we", wb_we, 32'd0);

    // 6: reset during WAIT aborts at once; late rvalid discarded
    drive_load(3'b010, 5'd9, 32'h400);
    cyc();
    delayed_load = 1'b0;
    dmem_gnt = 1'b1;
    cyc();
    dmem_gnt = 1'b0;
    chk("t6_wait_stall", load_stall_o, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_stall", load_stall_o, 32'd0);
    chk("t6_rst_req", dmem_req, 32'd0);
    chk("t6_rst_we", wb_we, 32'd0);
    chk("t6_rst_addr", dmem_addr, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFECAFE;
    cyc();
    dmem_rvalid = 1'b0;
    cyc();
    chk("t6_late_no_we", wb_we, 32'd0);
    chk("t6_late_stall", load_stall_o, 32'd0);
    do_load("t6_after", 3'b010, 5'd3, 32'h104, 32'h12345678, 32'h12345678);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
